// File: rtl/id_gen.sv
// rtl/id_gen.sv - identifier generator: letters, then digits, then optional terminator
// Optional terminator state enabled by defining ID_GEN_SEP_EN.
module id_gen #(
    parameter logic [7:0] SEP_CHAR = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] let_len,
    input  logic [3:0] dig_len,
    input  logic [4:0] let_base,
    input  logic [3:0] dig_base,
    input  logic       ready,
    output logic [7:0] char,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LET  = 2'd1,
        S_DIG  = 2'd2
`ifdef ID_GEN_SEP_EN
        ,
        S_SEP  = 2'd3
`endif
    } state_t;

`ifdef ID_GEN_SEP_EN
    localparam state_t TERM_STATE = S_SEP;
`else
    localparam state_t TERM_STATE = S_IDLE;
`endif

    state_t     state, state_nxt;
    logic [3:0] let_rem, let_rem_nxt;
    logic [3:0] dig_rem, dig_rem_nxt;
    logic [4:0] let_idx, let_idx_nxt;
    logic [3:0] dig_idx, dig_idx_nxt;
    logic [7:0] char_nxt;
    logic       valid_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       xfer;

    assign xfer = valid & ready;

    function automatic logic [4:0] clamp_let(input logic [4:0] b);
        return (b > 5'd25) ? 5'd25 : b;
    endfunction

    function automatic logic [3:0] clamp_dig(input logic [3:0] b);
        return (b > 4'd9) ? 4'd0 : b;
    endfunction

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            let_rem <= 4'd0;
            dig_rem <= 4'd0;
            let_idx <= 5'd0;
            dig_idx <= 4'd0;
            char    <= 8'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            let_rem <= let_rem_nxt;
            dig_rem <= dig_rem_nxt;
            let_idx <= let_idx_nxt;
            dig_idx <= dig_idx_nxt;
            char    <= char_nxt;
            valid   <= valid_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LET;
            S_LET: begin
                if (xfer && let_rem == 4'd1)
                    state_nxt = (dig_rem != 4'd0) ? S_DIG : TERM_STATE;
            end
            S_DIG: if (xfer && dig_rem == 4'd1) state_nxt = TERM_STATE;
`ifdef ID_GEN_SEP_EN
            S_SEP: if (xfer) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter updates: remaining counts step down and indices wrap on each transfer.
    always_comb begin
        let_rem_nxt = let_rem;
        dig_rem_nxt = dig_rem;
        let_idx_nxt = let_idx;
        dig_idx_nxt = dig_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    let_rem_nxt = (let_len == 4'd0) ? 4'd1 : let_len;
                    dig_rem_nxt = dig_len;
                    let_idx_nxt = clamp_let(let_base);
                    dig_idx_nxt = clamp_dig(dig_base);
                end
            end
            S_LET: begin
                if (xfer) begin
                    let_rem_nxt = let_rem - 4'd1;
                    let_idx_nxt = (let_idx == 5'd25) ? 5'd0 : let_idx + 5'd1;
                end
            end
            S_DIG: begin
                if (xfer) begin
                    dig_rem_nxt = dig_rem - 4'd1;
                    dig_idx_nxt = (dig_idx == 4'd9) ? 4'd0 : dig_idx + 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Next registered outputs follow the state being entered.
    always_comb begin
        char_nxt = 8'd0;
        case (state_nxt)
            S_LET:   char_nxt = 8'd97 + {3'b000, let_idx_nxt};
            S_DIG:   char_nxt = 8'd48 + {4'b0000, dig_idx_nxt};
`ifdef ID_GEN_SEP_EN
            S_SEP:   char_nxt = SEP_CHAR;
`endif
            default: char_nxt = 8'd0;
        endcase
        valid_nxt = (state_nxt != S_IDLE);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state != S_IDLE) && (state_nxt == S_IDLE);
    end

endmodule

// File: tb/tb_id_gen.sv
// tb/tb_id_gen.sv - randomized self-checking bench for id_gen against a queue-based character model
module tb_id_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] let_len;
    logic [3:0] dig_len;
    logic [4:0] let_base;
    logic [3:0] dig_base;
    logic       ready;
    logic [7:0] char;
    logic       valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    id_gen dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .let_len  (let_len),
        .dig_len  (dig_len),
        .let_base (let_base),
        .dig_base (dig_base),
        .ready    (ready),
        .char     (char),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    // Expected character stream computed directly from the identifier rules.
    task automatic build_expected(input int ll, input int dl, input int lb, input int db);
        int n;
        int b;
        int d;
        exp_q.delete();
        n = (ll == 0) ? 1 : ll;
        b = (lb > 25) ? 25 : lb;
        for (int i = 0; i < n; i++) exp_q.push_back(97 + (b + i) % 26);
        d = (db > 9) ? 0 : db;
        for (int i = 0; i < dl; i++) exp_q.push_back(48 + (d + i) % 10);
`ifdef ID_GEN_SEP_EN
        exp_q.push_back(32);
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low 3 cycles on the second char.
    task automatic run_seq(input string name, input int ll, input int dl, input int lb,
                           input int db, input int rmode, input bit poke, input bit idle_after);
        int idx;
        int cyc;
        int stall;
        idx = 0;
        cyc = 0;
        stall = 0;
        build_expected(ll, dl, lb, db);
        start    = 1'b1;
        let_len  = ll[3:0];
        dig_len  = dl[3:0];
        let_base = lb[4:0];
        dig_base = db[3:0];
        step();
        start    = 1'b0;
        let_len  = 4'($urandom);
        dig_len  = 4'($urandom);
        let_base = 5'($urandom);
        dig_base = 4'($urandom);
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_latency: valid=%b busy=%b required 1 1", name, valid, busy);
        end
        while (idx < exp_q.size() && cyc < 400) begin
            case (rmode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: begin
                    if (idx == 1 && stall < 3) begin
                        ready = 1'b0;
                        stall++;
                    end else begin
                        ready = 1'b1;
                    end
                end
            endcase
            if (poke && idx + 1 < exp_q.size()) begin
                start   = 1'($urandom_range(0, 1));
                let_len = 4'($urandom);
                dig_len = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || char !== 8'(exp_q[idx])) begin
                errors++;
                $display("FAIL %s char[%0d]: char=%0d valid=%b busy=%b done=%b required char=%0d valid=1 busy=1 done=0",
                         name, idx, char, valid, busy, done, exp_q[idx]);
            end
            if (ready) idx++;
            step();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: transferred %0d required %0d", name, idx, exp_q.size());
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: done=%b valid=%b busy=%b required 1 0 0", name, done, valid, busy);
        end
        if (idle_after) begin
            ready = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s idle: done=%b valid=%b busy=%b required 0 0 0", name, done, valid, busy);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (char !== 8'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: char=%0d valid=%b busy=%b done=%b required 0 0 0 0",
                     char, valid, busy, done);
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b busy=%b done=%b required 0 0 0", valid, busy, done);
        end
    endtask

    task automatic test_basic;
        run_seq("basic", 2, 3, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap;
        run_seq("wrap", 3, 2, 24, 9, 0, 1'b0, 1'b1);
    endtask

    task automatic test_clamp;
        run_seq("clamp", 0, 0, 30, 0, 0, 1'b0, 1'b1);
        run_seq("dig_clamp", 1, 4, 3, 12, 0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        run_seq("backpressure", 2, 3, 0, 0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        start    = 1'b1;
        let_len  = 4'd2;
        dig_len  = 4'd3;
        let_base = 5'd0;
        dig_base = 4'd0;
        ready    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checks++;
        if (char !== 8'd49 || valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: char=%0d valid=%b required 49 1", char, valid);
        end
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (char !== 8'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: char=%0d valid=%b busy=%b done=%b required 0 0 0 0",
                     char, valid, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone: done=%b valid=%b required 0 0", done, valid);
        end
        run_seq("after_reset", 2, 3, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_start_while_busy;
        run_seq("start_busy", 2, 3, 0, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_seq("b2b_a", 2, 1, 5, 3, 0, 1'b0, 1'b0);
        run_seq("b2b_b", 1, 2, 20, 8, 1, 1'b0, 1'b0);
        run_seq("b2b_c", 4, 0, 23, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++) begin
            run_seq("random", $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31),
                    $urandom_range(0, 15), 1, 1'b1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        ready    = 1'b0;
        let_len  = 4'd0;
        dig_len  = 4'd0;
        let_base = 5'd0;
        dig_base = 4'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_backpressure();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
